// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, data) onto one memory port with ack timeout.
// Optional macro ARB_ROUND_ROBIN_EN: alternate sides under contention instead of data-first priority.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_valid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic              dm_gnt_o,
   output logic              dm_valid_o,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              err_o,
   output logic [1:0]        state_o
);

   // Handshake: a request is held until the one-cycle gnt; the matching valid pulse
   // (with err on timeout) closes it, and rdata holds until that side's next completion.
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_DM = 2'd2} state_t;

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

   state_t     state;
   logic [7:0] wait_cnt;
   logic       pick_dm;

   assign state_o = state;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_if;

   // Reset value 1 makes the data side win the first contended arbitration.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         last_if <= 1'b1;
      else if (state == IDLE && (dm_req_i || if_req_i))
         last_if <= !pick_dm;
   end

   assign pick_dm = dm_req_i && (!if_req_i || last_if);
`else
   assign pick_dm = dm_req_i;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         if_gnt_o    <= 1'b0;
         if_valid_o  <= 1'b0;
         if_rdata_o  <= '0;
         dm_gnt_o    <= 1'b0;
         dm_valid_o  <= 1'b0;
         dm_rdata_o  <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         err_o       <= 1'b0;
      end else begin
         if_gnt_o   <= 1'b0;
         dm_gnt_o   <= 1'b0;
         if_valid_o <= 1'b0;
         dm_valid_o <= 1'b0;
         err_o      <= 1'b0;
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (pick_dm) begin
                  state       <= BUSY_DM;
                  dm_gnt_o    <= 1'b1;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= dm_we_i;
                  mem_addr_o  <= dm_addr_i;
                  mem_wdata_o <= dm_wdata_i;
               end else if (if_req_i) begin
                  state       <= BUSY_IF;
                  if_gnt_o    <= 1'b1;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= if_addr_i;
                  mem_wdata_o <= '0;
               end
            end
            BUSY_IF, BUSY_DM: begin
               // Ack takes precedence over a timeout landing on the same edge.
               if (mem_ack_i || wait_cnt == LAST_CNT) begin
                  state       <= IDLE;
                  wait_cnt    <= '0;
                  mem_req_o   <= 1'b0;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= '0;
                  mem_wdata_o <= '0;
                  err_o       <= !mem_ack_i;
                  if (state == BUSY_IF) begin
                     if_valid_o <= 1'b1;
                     if_rdata_o <= mem_ack_i ? mem_rdata_i : '1;
                  end else begin
                     dm_valid_o <= 1'b1;
                     dm_rdata_o <= mem_ack_i ? (mem_we_o ? '0 : mem_rdata_i) : '1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model compared every cycle plus literal checks.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_port_arbiter;

   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o, if_valid_o;
   logic [31:0] if_rdata_o;
   logic        dm_req_i, dm_we_i;
   logic [31:0] dm_addr_i, dm_wdata_i;
   logic        dm_gnt_o, dm_valid_o;
   logic [31:0] dm_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        err_o;
   logic [1:0]  state_dbg;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .if_gnt_o(if_gnt_o), .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_gnt_o(dm_gnt_o), .dm_valid_o(dm_valid_o), .dm_rdata_o(dm_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .err_o(err_o), .state_o(state_dbg)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   int          m_side  = 0;      // 0 none, 1 fetch, 2 data
   int          m_waited = 0;     // busy cycles elapsed
   int          m_win;
   logic [31:0] m_addr  = '0, m_wdata = '0;
   logic        m_we    = 1'b0;
   logic        m_last_if = 1'b1;
   logic        e_if_gnt = 0, e_dm_gnt = 0, e_if_valid = 0, e_dm_valid = 0, e_err = 0;
   logic [31:0] e_if_rdata = '0, e_dm_rdata = '0;
   bit          rr_mode;

   initial begin
`ifdef ARB_ROUND_ROBIN_EN
      rr_mode = 1'b1;
`else
      rr_mode = 1'b0;
`endif
   end

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_side = 0; m_waited = 0; m_last_if = 1'b1;
         e_if_gnt = 0; e_dm_gnt = 0; e_if_valid = 0; e_dm_valid = 0; e_err = 0;
         e_if_rdata = '0; e_dm_rdata = '0;
      end else begin
         e_if_gnt = 0; e_dm_gnt = 0; e_if_valid = 0; e_dm_valid = 0; e_err = 0;
         if (m_side == 0) begin
            if (dm_req_i && if_req_i) m_win = rr_mode ? (m_last_if ? 2 : 1) : 2;
            else if (dm_req_i)        m_win = 2;
            else if (if_req_i)        m_win = 1;
            else                      m_win = 0;
            if (m_win != 0) begin
               m_side = m_win;
               m_waited = 0;
               m_last_if = (m_win == 1);
               m_addr  = (m_win == 2) ? dm_addr_i : if_addr_i;
               m_we    = (m_win == 2) ? dm_we_i : 1'b0;
               m_wdata = (m_win == 2) ? dm_wdata_i : 32'h0;
               if (m_win == 2) e_dm_gnt = 1; else e_if_gnt = 1;
            end
         end else begin
            m_waited++;
            if (mem_ack_i || m_waited == TO) begin
               e_err = !mem_ack_i;
               if (m_side == 1) begin
                  e_if_valid = 1;
                  e_if_rdata = mem_ack_i ? mem_rdata_i : 32'hFFFF_FFFF;
               end else begin
                  e_dm_valid = 1;
                  e_dm_rdata = !mem_ack_i ? 32'hFFFF_FFFF : (m_we ? 32'h0 : mem_rdata_i);
               end
               m_side = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk_i) begin
      chk("if_gnt",     if_gnt_o,   e_if_gnt);
      chk("dm_gnt",     dm_gnt_o,   e_dm_gnt);
      chk("if_valid",   if_valid_o, e_if_valid);
      chk("dm_valid",   dm_valid_o, e_dm_valid);
      chk("err",        err_o,      e_err);
      chk("if_rdata",   if_rdata_o, e_if_rdata);
      chk("dm_rdata",   dm_rdata_o, e_dm_rdata);
      chk("mem_req",    mem_req_o,  m_side != 0);
      chk("state_idle", state_dbg == 2'd0, m_side == 0);
      chk("valid_excl", if_valid_o & dm_valid_o, 1'b0);
      if (m_side != 0) begin
         chk("mem_we",    mem_we_o,    m_we);
         chk("mem_addr",  mem_addr_o,  m_addr);
         chk("mem_wdata", mem_wdata_o, m_wdata);
      end
   end

   // ---------------- driver ----------------
   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic if_read(input logic [31:0] a, input int ack_at, input logic [31:0] d);
      if_req_i = 1; if_addr_i = a;
      cycle();
      chk("rd_gnt", if_gnt_o, 1'b1);
      if_req_i = 0;
      for (int k = 1; k <= TO; k++) begin
         if (k == ack_at) begin mem_ack_i = 1; mem_rdata_i = d; end
         cycle();
         mem_ack_i = 0;
         if (k == ack_at) break;
      end
      chk("rd_valid", if_valid_o, 1'b1);
      chk("rd_err",   err_o, (ack_at == 0) ? 1'b1 : 1'b0);
      chk("rd_data",  if_rdata_o, (ack_at == 0) ? 32'hFFFF_FFFF : d);
      cycle();
   endtask

   int gnt_q[$];
   int gnt_target;

   initial begin
      rst_i = 1; if_req_i = 0; if_addr_i = '0; dm_req_i = 0; dm_we_i = 0;
      dm_addr_i = '0; dm_wdata_i = '0; mem_ack_i = 0; mem_rdata_i = '0;
      repeat (2) cycle();
      chk("rst_mem_req", mem_req_o, 1'b0);
      chk("rst_addr",    mem_addr_o, 32'h0);
      rst_i = 0;
      cycle();

      // single fetch, ack on third busy cycle
      if_req_i = 1; if_addr_i = 32'h10;
      cycle();
      chk("f_gnt", if_gnt_o, 1'b1);
      chk("f_addr1", mem_addr_o, 32'h10);
      if_req_i = 0; if_addr_i = 32'h99;
      cycle();
      chk("f_gnt_once", if_gnt_o, 1'b0);
      chk("f_addr2", mem_addr_o, 32'h10);
      cycle();
      chk("f_addr3", mem_addr_o, 32'h10);
      mem_ack_i = 1; mem_rdata_i = 32'hDEADBEEF;
      cycle();
      mem_ack_i = 0;
      chk("f_valid", if_valid_o, 1'b1);
      chk("f_rdata", if_rdata_o, 32'hDEADBEEF);
      chk("f_req_off", mem_req_o, 1'b0);
      cycle();
      chk("f_valid_pulse", if_valid_o, 1'b0);
      chk("f_rdata_hold", if_rdata_o, 32'hDEADBEEF);

      // contention with immediate ack (ack held high through idle cycles too)
      gnt_target = rr_mode ? 4 : 2;
      if_req_i = 1; if_addr_i = 32'h30; dm_req_i = 1; dm_addr_i = 32'h20;
      mem_ack_i = 1; mem_rdata_i = 32'h5000;
      for (int c = 0; c < 16 && gnt_q.size() < gnt_target; c++) begin
         cycle();
         mem_rdata_i = mem_rdata_i + 32'h11;
         if (dm_gnt_o) begin gnt_q.push_back(2); if (!rr_mode) dm_req_i = 0; end
         if (if_gnt_o) begin gnt_q.push_back(1); if (!rr_mode) if_req_i = 0; end
      end
      if_req_i = 0; dm_req_i = 0;
      cycle();
      mem_ack_i = 0;
      cycle();
      chk("c_count", gnt_q.size(), gnt_target);
      if (gnt_q.size() >= 2) begin
         chk("c_first", gnt_q[0], 2);
         chk("c_second", gnt_q[1], 1);
      end
      if (rr_mode && gnt_q.size() >= 4) begin
         chk("c_third", gnt_q[2], 2);
         chk("c_fourth", gnt_q[3], 1);
      end

      // data write
      dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h40; dm_wdata_i = 32'h12345678;
      cycle();
      chk("w_we", mem_we_o, 1'b1);
      chk("w_wdata", mem_wdata_o, 32'h12345678);
      dm_req_i = 0; dm_we_i = 0; dm_wdata_i = 32'h0;
      mem_ack_i = 1; mem_rdata_i = 32'hAAAA5555;
      cycle();
      mem_ack_i = 0;
      chk("w_valid", dm_valid_o, 1'b1);
      chk("w_rdata", dm_rdata_o, 32'h0);
      cycle();

      // data read timeout: four busy cycles then valid+err
      dm_req_i = 1; dm_addr_i = 32'h50;
      cycle();
      dm_req_i = 0;
      for (int k = 2; k <= TO; k++) begin
         cycle();
         chk("t_busy", mem_req_o, 1'b1);
      end
      cycle();
      chk("t_valid", dm_valid_o, 1'b1);
      chk("t_err", err_o, 1'b1);
      chk("t_rdata", dm_rdata_o, 32'hFFFF_FFFF);
      chk("t_idle", mem_req_o, 1'b0);
      cycle();
      chk("t_err_pulse", err_o, 1'b0);

      // fetch ack latencies, including ack on the final allowed cycle and timeout
      if_read(32'h101, 1, 32'h0000_0101);
      if_read(32'h102, 2, 32'h0000_0202);
      if_read(32'h104, TO, 32'h0000_0404);
      if_read(32'h105, 0, 32'h0);

      // reset in second busy cycle
      if_req_i = 1; if_addr_i = 32'h60;
      cycle();
      if_req_i = 0;
      cycle();
      rst_i = 1;
      #1;
      chk("r_req_now", mem_req_o, 1'b0);
      cycle();
      rst_i = 0;
      mem_ack_i = 1; mem_rdata_i = 32'h1234;
      cycle();
      cycle();
      chk("r_no_valid", if_valid_o, 1'b0);
      chk("r_rdata", if_rdata_o, 32'h0);

      // stray ack while idle
      mem_rdata_i = 32'h777;
      repeat (3) cycle();
      chk("s_no_err", err_o, 1'b0);
      chk("s_dm_rdata", dm_rdata_o, 32'h0);
      mem_ack_i = 0;
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
